// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared state type and default constants for fifo_wr_arbiter
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int DEF_N_REQ      = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_BURST_LEN  = 4;
    localparam int STATS_W        = 16;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer request bundle plus the shared FIFO write port
interface fifo_wr_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8
);
    logic [N_REQ-1:0]            req;
    logic [N_REQ*DATA_WIDTH-1:0] wdata;
    logic [N_REQ-1:0]            gnt;
    logic [$clog2(N_REQ)-1:0]    owner;
    logic                        busy;
    logic                        fifo_full;
    logic                        fifo_w_en;
    logic [DATA_WIDTH-1:0]       fifo_data_in;

    modport master (
        input  req, wdata, fifo_full,
        output gnt, owner, busy, fifo_w_en, fifo_data_in
    );

    modport slave (
        output req, wdata, fifo_full,
        input  gnt, owner, busy, fifo_w_en, fifo_data_in
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin pick: first set req at or after ptr
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic             found_o,
    output logic [IW-1:0]    idx_o
);
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        // Walk offsets from farthest to nearest so the nearest hit overwrites the rest.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_i[IW'((int'(ptr_i) + i) % N_REQ)]) begin
                found_o = 1'b1;
                idx_o   = IW'((int'(ptr_i) + i) % N_REQ);
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for one FIFO write port; FIFO_ARB_STATS_EN adds beat counters
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BURST_LEN  = DEF_BURST_LEN
) (
    input  logic                     clk,
    input  logic                     reset,
`ifdef FIFO_ARB_STATS_EN
    input  logic                     stats_clr,
    output logic [N_REQ*STATS_W-1:0] beat_count,
`endif
    fifo_wr_arbiter_if.master        bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(BURST_LEN) + 1;

    arb_state_t            state_q, state_d;
    logic [IW-1:0]         owner_q, owner_d;
    logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]         beat_cnt_q, beat_cnt_d;
    logic [IW-1:0]         pick_idx;
    logic                  pick_found;
    logic                  w_en;
    logic [N_REQ-1:0]      gnt;
    logic [DATA_WIDTH-1:0] data_mux;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req_i   (bus.req),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        data_mux = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (owner_q == IW'(k)) begin
                data_mux = bus.wdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        w_en       = 1'b0;
        gnt        = '0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                // A full FIFO only freezes the burst; ownership and the beat count are kept.
                w_en = bus.req[owner_q] & ~bus.fifo_full;
                if (w_en) begin
                    gnt        = N_REQ'(1) << owner_q;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                if (!bus.req[owner_q] || (w_en && beat_cnt_d == CW'(BURST_LEN))) begin
                    rr_ptr_d = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.gnt          = gnt;
    assign bus.fifo_w_en    = w_en;
    assign bus.owner        = owner_q;
    assign bus.busy         = (state_q == BURST);
    assign bus.fifo_data_in = (state_q == BURST) ? data_mux : '0;

`ifdef FIFO_ARB_STATS_EN
    logic [STATS_W-1:0] stat_cnt_q [N_REQ];
    logic [STATS_W-1:0] stat_cnt_d [N_REQ];

    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            stat_cnt_d[k] = stat_cnt_q[k];
            if (stats_clr) begin
                stat_cnt_d[k] = '0;
            end else if (gnt[k] && stat_cnt_q[k] != '1) begin
                stat_cnt_d[k] = stat_cnt_q[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_REQ; k++) begin
                stat_cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                stat_cnt_q[k] <= stat_cnt_d[k];
            end
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_stats
        assign beat_count[g*STATS_W +: STATS_W] = stat_cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - randomized bench for fifo_wr_arbiter against a burst-level round-robin model
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BL = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus ();

`ifdef FIFO_ARB_STATS_EN
    logic                 stats_clr;
    logic [N*STATS_W-1:0] beat_count;
`endif

    fifo_wr_arbiter #(
        .N_REQ      (N),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef FIFO_ARB_STATS_EN
        .stats_clr  (stats_clr),
        .beat_count (beat_count),
`endif
        .bus        (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] rq [N][$];
    logic [DW-1:0] mq [N][$];
    int            exp_src[$], exp_bown[$], exp_blen[$];
    logic [DW-1:0] exp_data[$];
    int            log_src[$], log_bown[$], log_blen[$];
    logic [DW-1:0] log_data[$];
    bit            log_busy[$], log_wen[$];

    int fifo_cnt, fifo_lim, rd_pct, rd_req;
    logic          s_busy, s_wen;
    logic [N-1:0]  s_gnt;
    logic [DW-1:0] s_data;
    int            s_owner;
    bit            prev_busy;

    function automatic bit all_empty();
        for (int k = 0; k < N; k++) if (rq[k].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    // Burst-level expectation: owner = first non-empty queue at/after ptr, takes min(BL, left) beats.
    task automatic model();
        int ptr, owner, n;
        bit hit;
        exp_src.delete(); exp_data.delete(); exp_bown.delete(); exp_blen.delete();
        for (int k = 0; k < N; k++) mq[k] = rq[k];
        ptr = 0;
        for (int b = 0; b < 1000; b++) begin
            hit = 1'b0;
            owner = 0;
            for (int i = 0; i < N; i++) begin
                if (!hit && mq[(ptr + i) % N].size() > 0) begin
                    hit = 1'b1;
                    owner = (ptr + i) % N;
                end
            end
            if (!hit) break;
            n = (mq[owner].size() < BL) ? mq[owner].size() : BL;
            exp_bown.push_back(owner);
            exp_blen.push_back(n);
            repeat (n) begin
                exp_src.push_back(owner);
                exp_data.push_back(mq[owner].pop_front());
            end
            ptr = (owner + 1) % N;
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            bus.req[k] = (rq[k].size() > 0);
            bus.wdata[k*DW +: DW] = (rq[k].size() > 0) ? rq[k][0] : DW'($urandom);
        end
        bus.fifo_full = (fifo_cnt >= fifo_lim);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int k = 0; k < N; k++) rq[k].delete();
        bus.req = '0;
        bus.wdata = '0;
        bus.fifo_full = 1'b0;
`ifdef FIFO_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        fifo_cnt = 0; fifo_lim = 8; rd_pct = 100; rd_req = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic cycle();
        int src;
        src = 0;
        @(negedge clk);
        s_gnt = bus.gnt; s_wen = bus.fifo_w_en; s_data = bus.fifo_data_in;
        s_busy = bus.busy; s_owner = int'(bus.owner);
        total++;
        if ($countones(s_gnt) > 1) begin
            bad++; $display("FAIL gnt_onehot got=%b want=at most one bit", s_gnt);
        end
        total++;
        if ((s_gnt != '0) !== s_wen) begin
            bad++; $display("FAIL gnt_vs_wen got gnt=%b w_en=%b want gnt nonzero exactly when w_en", s_gnt, s_wen);
        end
        if (s_wen) begin
            for (int i = 0; i < N; i++) if (s_gnt[i]) src = i;
            total++;
            if (bus.fifo_full !== 1'b0) begin
                bad++; $display("FAIL wen_while_full got w_en=1 want 0 while full");
            end
            total++;
            if (s_owner !== src) begin
                bad++; $display("FAIL owner_vs_gnt got owner=%0d want=%0d", s_owner, src);
            end
            total++;
            if (rq[src].size() == 0 || s_data !== rq[src][0]) begin
                bad++; $display("FAIL write_data got=%h want head of requester %0d", s_data, src);
            end
        end
        if (!s_busy) begin
            total++;
            if (s_wen !== 1'b0 || s_data !== '0) begin
                bad++; $display("FAIL idle_outputs got w_en=%b data=%h want 0/0", s_wen, s_data);
            end
        end
        if (s_busy && !prev_busy) begin
            log_bown.push_back(s_owner);
            log_blen.push_back(0);
        end
        if (s_wen && log_blen.size() > 0) log_blen[log_blen.size()-1] = log_blen[log_blen.size()-1] + 1;
        prev_busy = s_busy;
        log_busy.push_back(s_busy);
        log_wen.push_back(s_wen);
        @(posedge clk);
        #1;
        if (s_wen) begin
            log_src.push_back(src);
            log_data.push_back(s_data);
            if (rq[src].size() > 0) void'(rq[src].pop_front());
            fifo_cnt++;
        end
        if (fifo_cnt > 0 && (rd_req > 0 || $urandom_range(0, 99) < rd_pct)) begin
            fifo_cnt--;
            if (rd_req > 0) rd_req--;
        end
        drive();
    endtask

    task automatic start_run();
        log_src.delete(); log_data.delete(); log_bown.delete(); log_blen.delete();
        log_busy.delete(); log_wen.delete();
        prev_busy = 1'b0;
        model();
        drive();
    endtask

    task automatic finish_run(input string name, input int max_cyc);
        bit done;
        done = 1'b0;
        for (int c = 0; c < max_cyc && !done; c++) begin
            cycle();
            if (all_empty() && !s_busy) done = 1'b1;
        end
        total++;
        if (!done) begin
            bad++; $display("FAIL %s timeout got=not drained want=drained within %0d cycles", name, max_cyc);
        end
        total++;
        if (log_src.size() != exp_src.size()) begin
            bad++; $display("FAIL %s write_count got=%0d want=%0d", name, log_src.size(), exp_src.size());
        end
        for (int i = 0; i < log_src.size() && i < exp_src.size(); i++) begin
            total++;
            if (log_src[i] !== exp_src[i] || log_data[i] !== exp_data[i]) begin
                bad++; $display("FAIL %s write[%0d] got=%0d/%h want=%0d/%h", name, i,
                                log_src[i], log_data[i], exp_src[i], exp_data[i]);
            end
        end
        total++;
        if (log_bown.size() != exp_bown.size()) begin
            bad++; $display("FAIL %s burst_count got=%0d want=%0d", name, log_bown.size(), exp_bown.size());
        end
        for (int i = 0; i < log_bown.size() && i < exp_bown.size(); i++) begin
            total++;
            if (log_bown[i] !== exp_bown[i] || log_blen[i] !== exp_blen[i]) begin
                bad++; $display("FAIL %s burst[%0d] got owner=%0d len=%0d want owner=%0d len=%0d", name, i,
                                log_bown[i], log_blen[i], exp_bown[i], exp_blen[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req = '1;
        bus.wdata = {N*DW{1'b1}};
        bus.fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.gnt !== '0 || bus.fifo_w_en !== 1'b0 ||
            bus.fifo_data_in !== '0 || bus.owner !== '0) begin
            bad++; $display("FAIL reset_outputs got busy=%b gnt=%b w_en=%b data=%h owner=%0d want all 0",
                            bus.busy, bus.gnt, bus.fifo_w_en, bus.fifo_data_in, bus.owner);
        end
    endtask

    task automatic test_single();
        bit eb [9];
        bit ew [9];
        eb = '{0, 1, 1, 1, 1, 0, 1, 1, 0};
        ew = '{0, 1, 1, 1, 1, 0, 1, 0, 0};
        do_reset();
        for (int v = 16; v <= 20; v++) rq[0].push_back(DW'(v));
        start_run();
        finish_run("single", 200);
        total++;
        if (log_busy.size() != 9) begin
            bad++; $display("FAIL single_cycles got=%0d want=9", log_busy.size());
        end
        for (int i = 0; i < 9 && i < log_busy.size(); i++) begin
            total++;
            if (log_busy[i] !== eb[i] || log_wen[i] !== ew[i]) begin
                bad++; $display("FAIL single_timing cycle %0d got busy=%b w_en=%b want busy=%b w_en=%b",
                                i, log_busy[i], log_wen[i], eb[i], ew[i]);
            end
        end
    endtask

    task automatic test_contention();
        int eo [4];
        eo = '{0, 1, 3, 0};
        do_reset();
        repeat (8) rq[0].push_back(DW'($urandom));
        repeat (4) rq[1].push_back(DW'($urandom));
        repeat (4) rq[3].push_back(DW'($urandom));
        start_run();
        finish_run("contention", 300);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= log_bown.size() || log_bown[i] !== eo[i] || log_blen[i] !== BL) begin
                bad++; $display("FAIL contention_order burst %0d got owner=%0d want owner=%0d len=%0d", i,
                                (i < log_bown.size()) ? log_bown[i] : -1, eo[i], BL);
            end
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        fifo_lim = 8; fifo_cnt = 7; rd_pct = 0;
        repeat (4) rq[2].push_back(DW'($urandom));
        start_run();
        cycle();
        cycle();
        total++;
        if (s_wen !== 1'b1) begin
            bad++; $display("FAIL stall_first_beat got w_en=%b want 1", s_wen);
        end
        repeat (4) begin
            cycle();
            total++;
            if (s_wen !== 1'b0 || s_busy !== 1'b1 || s_owner !== 2) begin
                bad++; $display("FAIL stall_hold got w_en=%b busy=%b owner=%0d want 0/1/2", s_wen, s_busy, s_owner);
            end
        end
        rd_req = 1;
        cycle();
        total++;
        if (s_wen !== 1'b0) begin
            bad++; $display("FAIL stall_before_read got w_en=%b want 0", s_wen);
        end
        cycle();
        total++;
        if (s_wen !== 1'b1) begin
            bad++; $display("FAIL stall_release got w_en=%b want 1", s_wen);
        end
        cycle();
        total++;
        if (s_wen !== 1'b0 || s_busy !== 1'b1) begin
            bad++; $display("FAIL stall_refull got w_en=%b busy=%b want 0/1", s_wen, s_busy);
        end
        rd_pct = 100;
        finish_run("full_stall", 200);
        total++;
        if (log_bown.size() != 1 || log_blen[0] !== 4) begin
            bad++; $display("FAIL stall_single_burst got bursts=%0d want one burst of 4", log_bown.size());
        end
    endtask

    task automatic test_early_drop();
        int eo [4];
        int el [4];
        eo = '{0, 2, 3, 0};
        el = '{4, 2, 3, 2};
        do_reset();
        repeat (6) rq[0].push_back(DW'($urandom));
        repeat (2) rq[2].push_back(DW'($urandom));
        repeat (3) rq[3].push_back(DW'($urandom));
        start_run();
        finish_run("early_drop", 300);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= log_bown.size() || log_bown[i] !== eo[i] || log_blen[i] !== el[i]) begin
                bad++; $display("FAIL early_drop burst %0d got owner=%0d want owner=%0d len=%0d", i,
                                (i < log_bown.size()) ? log_bown[i] : -1, eo[i], el[i]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        repeat (6) rq[1].push_back(DW'($urandom));
        start_run();
        repeat (3) cycle();
        total++;
        if (log_data.size() != 2 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL pre_reset got beats=%0d busy=%b want 2/1", log_data.size(), bus.busy);
        end
        reset = 1'b1;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.gnt !== '0 || bus.fifo_w_en !== 1'b0 || bus.fifo_data_in !== '0) begin
            bad++; $display("FAIL async_reset got busy=%b gnt=%b w_en=%b data=%h want all 0",
                            bus.busy, bus.gnt, bus.fifo_w_en, bus.fifo_data_in);
        end
        repeat (3) rq[0].push_back(DW'($urandom));
        drive();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        start_run();
        finish_run("after_reset", 300);
        total++;
        if (log_bown.size() == 0 || log_bown[0] !== 0) begin
            bad++; $display("FAIL restart_owner got=%0d want=0", (log_bown.size() > 0) ? log_bown[0] : -1);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            do_reset();
            fifo_lim = $urandom_range(1, 8);
            rd_pct = $urandom_range(20, 90);
            for (int k = 0; k < N; k++) begin
                repeat ($urandom_range(0, 9)) rq[k].push_back(DW'($urandom));
            end
            start_run();
            finish_run("random", 3000);
        end
    endtask

`ifdef FIFO_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        repeat (10) rq[1].push_back(DW'($urandom));
        start_run();
        finish_run("stats", 300);
        for (int k = 0; k < N; k++) begin
            total++;
            if (beat_count[k*STATS_W +: STATS_W] !== ((k == 1) ? 16'd10 : 16'd0)) begin
                bad++; $display("FAIL stats_count[%0d] got=%0d want=%0d", k,
                                beat_count[k*STATS_W +: STATS_W], (k == 1) ? 10 : 0);
            end
        end
        stats_clr = 1'b1;
        @(posedge clk);
        #1;
        stats_clr = 1'b0;
        total++;
        if (beat_count !== '0) begin
            bad++; $display("FAIL stats_clr got=%h want=0", beat_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        do_reset();
        test_single();
        test_contention();
        test_full_stall();
        test_early_drop();
        test_reset_mid_burst();
        test_random();
`ifdef FIFO_ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog got=still running want=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one `fifo` write port (`w_en`, `data_in`, `full`) between `N_REQ` producers. It grants the port to one requester at a time for a burst of up to `BURST_LEN` beats, stalls on `full`, and rotates priority after each burst. It sits directly in front of the `fifo` instance; the FIFO's read side is untouched.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `DATA_WIDTH`, 8, beat width; must match the FIFO
- `BURST_LEN`, 4, maximum accepted beats per grant (1..16)

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `req`  in  N_REQ  per-requester "beat available"; held while data is valid
- `wdata`  in  N_REQ*DATA_WIDTH  flattened beats; requester k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- `gnt`  out  N_REQ  one-hot, high only in a cycle where the owner's beat is written
- `owner`  out  $clog2(N_REQ)  current burst owner index; valid while `busy`
- `busy`  out  1  high in BURST state
- `fifo_full`  in  1  from FIFO `full`
- `fifo_w_en`  out  1  to FIFO `w_en`
- `fifo_data_in`  out  DATA_WIDTH  to FIFO `data_in`

## Operation
- FSM states: IDLE, BURST.
- IDLE: if any `req` is high, pick the first set bit at or after `rr_ptr`, scanning upward with wrap. Latch it into `owner`, clear `beat_cnt`, go to BURST. Otherwise stay in IDLE.
- BURST: `fifo_w_en = req[owner] & ~fifo_full`. `fifo_data_in = wdata[owner]`. `gnt = onehot(owner) & {N_REQ{fifo_w_en}}`.
- Each accepted beat increments `beat_cnt`. `beat_cnt` is $clog2(BURST_LEN)+1 bits wide and never wraps.
- A burst ends when either:
  - an accepted beat brings `beat_cnt` to BURST_LEN, or
  - `req[owner]` is low during BURST.
- At burst end: `rr_ptr <= (owner == N_REQ-1) ? 0 : owner+1`, and the FSM returns to IDLE.
- `fifo_full` high in BURST: no beat is written, `gnt` is 0, `beat_cnt` holds, and ownership is kept. There is no timeout.
- Simultaneous requests: exactly one requester wins, decided by `rr_ptr`. Losers keep `req` asserted and are not dropped.
- `fifo_w_en` and `fifo_data_in` are combinational from registered state plus `req`, `wdata` and `fifo_full`. `fifo_data_in` is 0 outside BURST.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `owner` 0, `beat_cnt` 0. Outputs `gnt` 0, `busy` 0, `fifo_w_en` 0, `fifo_data_in` 0.
- Reset asserted mid-burst aborts immediately. No partial-burst bookkeeping survives.
- Latency:
  - `req` rising while IDLE → `busy` after the next clock edge.
  - First beat is written on the edge after that, so 2 edges from req to FIFO write.
- Throughput in BURST is 1 beat/cycle while `~fifo_full`.
- After a burst there is a 1-cycle IDLE bubble before the next burst.
- Handshake: the requester treats `gnt[k]` high at a rising edge as "beat consumed" and presents the next beat or drops `req` in the following cycle.

## Configuration
- `FIFO_ARB_STATS_EN` defined:
  - Adds output `beat_count`, N_REQ*16 bits: per-requester saturating counters of accepted beats (hold at 16'hFFFF).
  - Adds input `stats_clr`, a synchronous clear to 0.
  - Counters reset to 0 on `reset`.
- Undefined: neither port exists, no counter logic is built, and arbitration behaviour is identical.

## Structure
- Package `fifo_arb_pkg` holds:
  - the state enum `arb_state_t` {IDLE, BURST}
  - the default `DATA_WIDTH`/`BURST_LEN` constants
  - the stats counter width constant (16)
- Sub-module `rr_pick`: purely combinational. Takes `req` vector and `rr_ptr`, returns `found` plus the index; parameterised on N_REQ.
- FSM, counters and output mux live in `fifo_wr_arbiter`.

## Test plan
- **Single requester:** `req=4'b0001` with data 16,17,18,19,20 → 4 writes with `gnt[0]`, 1 IDLE cycle, then beat 20 written. FIFO reads back 16..20 in order.
- **Contention:** `req=4'b1011` held, `BURST_LEN=4` → owner order 0,1,3,0. Each burst is 4 beats, and `gnt` is never multi-hot.
- **Full stall:** FIFO at depth-1 when a burst of 4 starts → 1 beat written, then `fifo_w_en=0` and `beat_cnt=1` hold while `full`. After one read frees a slot, one beat is written.
- **Early drop:** owner 2 drops `req` after 2 beats → burst ends with `beat_cnt=2` and `rr_ptr=3`. The next grant goes to requester 3 if requesting.
- **Reset mid-burst:** `reset` pulsed after beat 2 of a burst → `busy`, `gnt` and `fifo_w_en` drop asynchronously. After release, arbitration restarts at requester 0.
- **Stats (with `FIFO_ARB_STATS_EN`):** 10 beats from requester 1 → `beat_count[1]=10`, all others 0. `stats_clr` → all 0.
